// File: rtl/win_check_sequencer_if.sv
// Bundle of the request, checker and board-read-port signals around win_check_sequencer.
// The slave modport is the sequencer; the master modport is whatever surrounds it.
interface win_check_sequencer_if;
    logic       check_req;
    logic [2:0] drop_row;
    logic [2:0] drop_col;
    logic       busy;
    logic       done;
    logic       win;
    logic [1:0] winner;
    logic [3:0] win_dir;

    logic       chk_start;
    logic [2:0] chk_row;
    logic [2:0] chk_col;
    logic [3:0] chk_direction;
    logic       chk_finished;
    logic [1:0] chk_winner;
    logic [2:0] chk_rd_row;
    logic [2:0] chk_rd_col;

    logic       host_rd_req;
    logic [2:0] host_rd_row;
    logic [2:0] host_rd_col;
    logic       host_rd_gnt;
    logic [2:0] mem_rd_row;
    logic [2:0] mem_rd_col;

    modport slave (
        input  check_req, drop_row, drop_col,
        output busy, done, win, winner, win_dir,
        output chk_start, chk_row, chk_col, chk_direction,
        input  chk_finished, chk_winner, chk_rd_row, chk_rd_col,
        input  host_rd_req, host_rd_row, host_rd_col,
        output host_rd_gnt, mem_rd_row, mem_rd_col
    );

    modport master (
        output check_req, drop_row, drop_col,
        input  busy, done, win, winner, win_dir,
        input  chk_start, chk_row, chk_col, chk_direction,
        output chk_finished, chk_winner, chk_rd_row, chk_rd_col,
        output host_rd_req, host_rd_row, host_rd_col,
        input  host_rd_gnt, mem_rd_row, mem_rd_col
    );
endinterface

// File: rtl/win_check_sequencer.sv
// Purpose: walks directions 1..13 after a drop, starts the checker on in-board windows only, arbitrates the board read port.
// Latency: 1 cycle per skipped direction, START + checker time per legal one, stops on the first win.
// Backpressure: check_req while busy is dropped; host reads are refused while busy, otherwise granted combinationally.
module win_check_sequencer #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    win_check_sequencer_if.slave  bus
);

    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
    localparam logic [3:0] COL_MAX = 4'(COLS - 1);
    localparam logic [3:0] DIR_LAST = 4'd13;

    typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, FINISH} state_t;

    state_t     state_q, state_d;
    logic [3:0] dir_q, dir_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       win_q, win_d;
    logic [1:0] winner_q, winner_d;
    logic [3:0] win_dir_q, win_dir_d;
    logic       busy;
    logic       gnt;

    // Window cells are row r-back..r+fwd; all sums done in 4 bits so edge cells cannot wrap.
    function automatic logic dir_legal(input logic [3:0] d, input logic [2:0] row, input logic [2:0] col);
        logic [3:0] r, c, k, back, fwd;
        logic       ok;
        r  = {1'b0, row};
        c  = {1'b0, col};
        k  = 4'd1;
        ok = 1'b0;
        if (d >= 4'd2 && d <= 4'd5)
            k = d - 4'd1;
        else if (d >= 4'd6 && d <= 4'd9)
            k = d - 4'd5;
        else if (d >= 4'd10 && d <= 4'd13)
            k = d - 4'd9;
        back = 4'd4 - k;
        fwd  = k - 4'd1;
        if (d == 4'd1)
            ok = (r >= 4'd3);
        else if (d >= 4'd2 && d <= 4'd5)
            ok = (c >= back) && (c + fwd <= COL_MAX);
        else if (d >= 4'd6 && d <= 4'd9)
            ok = (r >= back) && (c >= back) && (r + fwd <= ROW_MAX) && (c + fwd <= COL_MAX);
        else if (d >= 4'd10 && d <= 4'd13)
            ok = (r >= back) && (c >= fwd) && (r + fwd <= ROW_MAX) && (c + back <= COL_MAX);
        return ok;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= 4'd0;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            win_q     <= 1'b0;
            winner_q  <= 2'd0;
            win_dir_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            row_q     <= row_d;
            col_q     <= col_d;
            win_q     <= win_d;
            winner_q  <= winner_d;
            win_dir_q <= win_dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        row_d     = row_q;
        col_d     = col_q;
        win_d     = win_q;
        winner_d  = winner_q;
        win_dir_d = win_dir_q;
        case (state_q)
            IDLE: begin
                if (bus.check_req) begin
                    row_d     = bus.drop_row;
                    col_d     = bus.drop_col;
                    dir_d     = 4'd1;
                    win_d     = 1'b0;
                    winner_d  = 2'd0;
                    win_dir_d = 4'd0;
                    state_d   = SELECT;
                end
            end
            SELECT: begin
                if (dir_legal(dir_q, row_q, col_q))
                    state_d = START;
                else if (dir_q == DIR_LAST)
                    state_d = FINISH;
                else
                    dir_d = dir_q + 4'd1;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.chk_finished) begin
                    // An all-empty window reports 00 and must not count as a win.
                    if (bus.chk_winner != 2'd0) begin
                        win_d     = 1'b1;
                        winner_d  = bus.chk_winner;
                        win_dir_d = dir_q;
                        state_d   = FINISH;
                    end else if (dir_q == DIR_LAST) begin
                        state_d = FINISH;
                    end else begin
                        dir_d   = dir_q + 4'd1;
                        state_d = SELECT;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SELECT) || (state_q == START) || (state_q == WAIT);
    assign gnt  = bus.host_rd_req && !busy;

    assign bus.busy          = busy;
    assign bus.done          = (state_q == FINISH);
    assign bus.win           = win_q;
    assign bus.winner        = winner_q;
    assign bus.win_dir       = win_dir_q;
    assign bus.chk_start     = (state_q == START);
    assign bus.chk_row       = row_q;
    assign bus.chk_col       = col_q;
    assign bus.chk_direction = dir_q;
    assign bus.host_rd_gnt   = gnt;
    assign bus.mem_rd_row    = gnt ? bus.host_rd_row : bus.chk_rd_row;
    assign bus.mem_rd_col    = gnt ? bus.host_rd_col : bus.chk_rd_col;

endmodule

// File: tb/tb_win_check_sequencer.sv
// Directed bench for win_check_sequencer with a small direction_checker stand-in that answers 3 cycles after each start.
module tb_win_check_sequencer;

    logic clk;
    logic rst_n;
    win_check_sequencer_if bus ();

    win_check_sequencer #(.ROWS(6), .COLS(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Checker stand-in: logs every started direction, reports cfg_player on cfg_dir, 00 elsewhere.
    int         started[$];
    logic [3:0] cfg_dir;
    logic [1:0] cfg_player;
    int         cnt;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= 0;
            bus.chk_finished <= 1'b0;
            bus.chk_winner   <= 2'd0;
        end else begin
            bus.chk_finished <= 1'b0;
            bus.chk_winner   <= 2'd0;
            if (bus.chk_start) begin
                started.push_back(int'(bus.chk_direction));
                cnt <= 3;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    bus.chk_finished <= 1'b1;
                    bus.chk_winner   <= (bus.chk_direction == cfg_dir) ? cfg_player : 2'd0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send_req(input logic [2:0] r, input logic [2:0] c);
        @(negedge clk);
        bus.check_req = 1'b1;
        bus.drop_row  = r;
        bus.drop_col  = c;
        @(negedge clk);
        bus.check_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_start_dir(input string tag, input logic [3:0] d);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.chk_start && bus.chk_direction == d) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_log(input string tag, input int n, input int e0, input int e1, input int e2, input int e3);
        int exp_l[4];
        exp_l = '{e0, e1, e2, e3};
        check_eq({tag, "_count"}, 32'(started.size()), 32'(n));
        for (int i = 0; i < n && i < started.size(); i++)
            check_eq($sformatf("%s_dir%0d", tag, i), 32'(started[i]), 32'(exp_l[i]));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},    32'(bus.busy),          32'd0);
        check_eq({tag, "_done"},    32'(bus.done),          32'd0);
        check_eq({tag, "_win"},     32'(bus.win),           32'd0);
        check_eq({tag, "_winner"},  32'(bus.winner),        32'd0);
        check_eq({tag, "_win_dir"}, 32'(bus.win_dir),       32'd0);
        check_eq({tag, "_start"},   32'(bus.chk_start),     32'd0);
        check_eq({tag, "_row"},     32'(bus.chk_row),       32'd0);
        check_eq({tag, "_col"},     32'(bus.chk_col),       32'd0);
        check_eq({tag, "_dir"},     32'(bus.chk_direction), 32'd0);
        check_eq({tag, "_gnt"},     32'(bus.host_rd_gnt),   32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.check_req   = 1'b0;
        bus.drop_row    = 3'd0;
        bus.drop_col    = 3'd0;
        bus.chk_rd_row  = 3'd2;
        bus.chk_rd_col  = 3'd5;
        bus.host_rd_req = 1'b0;
        bus.host_rd_row = 3'd6;
        bus.host_rd_col = 3'd1;
        cfg_dir         = 4'd0;
        cfg_player      = 2'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        rst_n = 1'b1;

        // (1) reset while waiting on direction 4 of a (3,3) drop
        send_req(3'd3, 3'd3);
        wait_start_dir("t1_reach_dir4", 4'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t1_abort");
        check_log("t1", 4, 1, 2, 3, 4);
        begin
            logic saw_done;
            saw_done = 1'b0;
            repeat (2) begin
                @(negedge clk);
                saw_done |= bus.done;
            end
            rst_n = 1'b1;
            repeat (2) begin
                @(negedge clk);
                saw_done |= bus.done;
            end
            check_eq("t1_no_done", 32'(saw_done), 32'd0);
        end
        started.delete();

        // (2) corner drop (0,0), checker never reports a winner
        send_req(3'd0, 3'd0);
        check_eq("t2_restart_dir", 32'(bus.chk_direction), 32'd1);
        check_eq("t2_busy",        32'(bus.busy),          32'd1);
        wait_done("t2_done");
        check_eq("t2_busy_at_done", 32'(bus.busy), 32'd0);
        check_eq("t2_win",          32'(bus.win),  32'd0);
        check_eq("t2_winner",       32'(bus.winner), 32'd0);
        check_eq("t2_win_dir",      32'(bus.win_dir), 32'd0);
        @(negedge clk);
        check_eq("t2_done_pulse", 32'(bus.done), 32'd0);
        check_log("t2", 2, 5, 9, 0, 0);
        started.delete();

        // (3) win on the very first direction
        cfg_dir    = 4'd1;
        cfg_player = 2'd1;
        send_req(3'd3, 3'd3);
        wait_done("t3_done");
        check_eq("t3_win",     32'(bus.win),     32'd1);
        check_eq("t3_winner",  32'(bus.winner),  32'd1);
        check_eq("t3_win_dir", 32'(bus.win_dir), 32'd1);
        check_log("t3", 1, 1, 0, 0, 0);
        started.delete();

        // (4) top-right corner (5,6), win on the up-right diagonal
        cfg_dir    = 4'd6;
        cfg_player = 2'd2;
        send_req(3'd5, 3'd6);
        check_eq("t4_row", 32'(bus.chk_row), 32'd5);
        check_eq("t4_col", 32'(bus.chk_col), 32'd6);
        wait_done("t4_done");
        check_eq("t4_win_dir", 32'(bus.win_dir), 32'd6);
        check_log("t4", 3, 1, 2, 6, 0);
        repeat (5) @(negedge clk);
        check_eq("t4_hold_win",     32'(bus.win),     32'd1);
        check_eq("t4_hold_winner",  32'(bus.winner),  32'd2);
        check_eq("t4_hold_win_dir", 32'(bus.win_dir), 32'd6);
        check_eq("t4_idle_nogrant", 32'(bus.host_rd_gnt), 32'd0);
        check_eq("t4_idle_mux_row", 32'(bus.mem_rd_row),  32'd2);
        started.delete();

        // (5) ignored re-request and host arbitration
        cfg_dir    = 4'd0;
        cfg_player = 2'd0;
        send_req(3'd0, 3'd0);
        check_eq("t5_win_cleared",    32'(bus.win),     32'd0);
        check_eq("t5_winner_cleared", 32'(bus.winner),  32'd0);
        check_eq("t5_dir_cleared",    32'(bus.win_dir), 32'd0);
        wait_start_dir("t5_reach_dir5", 4'd5);
        @(negedge clk);
        bus.check_req   = 1'b1;
        bus.drop_row    = 3'd3;
        bus.drop_col    = 3'd3;
        bus.host_rd_req = 1'b1;
        #1;
        check_eq("t5_busy_gnt",     32'(bus.host_rd_gnt), 32'd0);
        check_eq("t5_busy_mux_row", 32'(bus.mem_rd_row),  32'd2);
        check_eq("t5_busy_mux_col", 32'(bus.mem_rd_col),  32'd5);
        @(negedge clk);
        bus.check_req = 1'b0;
        wait_done("t5_done");
        check_eq("t5_row_kept", 32'(bus.chk_row), 32'd0);
        check_log("t5", 2, 5, 9, 0, 0);
        @(negedge clk);
        check_eq("t5_idle_gnt",     32'(bus.host_rd_gnt), 32'd1);
        check_eq("t5_idle_mux_row", 32'(bus.mem_rd_row),  32'd6);
        check_eq("t5_idle_mux_col", 32'(bus.mem_rd_col),  32'd1);
        repeat (4) @(negedge clk);
        check_eq("t5_not_queued", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
